csa_8_seq_adder: RTL and testbench
==================================

// Module: csa_8_seq_adder
// PURPOSE
//  Multi-precision adder sequencer: one shared CSA_8 (ports A,B,S,carry; no carry-in) computes
//  NBYTES-wide sums byte-serially, LSB first.
//  CSA_8 has no carry-in, so carry is injected by a second pass per byte.
//  Sits between a valid/ready producer and consumer.
//  It is the only driver of its internal CSA_8 instance.
// PARAMETERS
//  NBYTES  4  operand width in bytes (>=1); data width W = 8*NBYTES
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous active-high reset
//  in_valid   in   1   operands a, b, cin valid
//  in_ready   out  1   block accepts operands (== state IDLE)
//  a          in   W   operand A
//  b          in   W   operand B
//  cin        in   1   carry-in to byte 0
//  out_valid  out  1   sum/cout valid (== state DONE)
//  out_ready  in   1   consumer accepts result
//  sum        out  W   registered result
//  cout       out  1   registered carry-out of MSB byte
//  busy       out  1   state is ADD or INC
// BEHAVIOUR
//  Reset values: state=IDLE, sum=0, cout=0, internal byte index=0, carry reg cr=0, c1 reg=0.
//   Hence in_ready=1, out_valid=0, busy=0.
//  FSM states: IDLE, ADD, INC, DONE.
//  IDLE: on in_valid&in_ready, latch a, b; cr<=cin; idx<=0; go to ADD. a/b ignored afterwards.
//  ADD, byte idx: CSA_8 A=a[idx], B=b[idx]; p<=S; c1<=carry; go to INC.
//  INC, byte idx: CSA_8 A=p, B={7'b0,cr}.
//   - sum[idx]<=S; cr<=c1|carry; c1 and carry are never both 1.
//   - If idx==NBYTES-1: cout<=c1|carry, go to DONE.
//   - Else: idx<=idx+1, go to ADD.
//  DONE: out_valid=1; sum/cout stable.
//   - On out_ready, go to IDLE. Without out_ready, hold indefinitely.
//  No accept in DONE. Back-to-back ops need one IDLE cycle.
//  sum/cout persist through IDLE until next completion. sum bytes are overwritten progressively during ADD/INC.
//  Arithmetic: {cout,sum} = a + b + cin, mod 2^(W+1). No overflow flag.
//  Latency: out_valid rises exactly 2*NBYTES clock edges after the accepting edge (8 for NBYTES=4).
//  rst mid-operation: immediate return to reset values; partial result discarded; no out_valid pulse.
//  CSA_8 inputs are driven 0 in IDLE/DONE to avoid toggling.
// CONFIGURATION
//  SKIP_INC_EN defined:
//   - In ADD, if cr==0: sum[idx]<=S and cr<=carry directly; INC is skipped.
//     Next state is ADD(idx+1), or DONE with cout<=carry on the last byte.
//   - Latency varies from NBYTES to 2*NBYTES edges.
//  SKIP_INC_EN undefined:
//   - INC is always executed; fixed 2*NBYTES latency.
//  Results are identical in both builds.
// TESTING
//  T1: a=0x00000019, b=0x00000025, cin=0 -> sum=0x0000003E, cout=0; out_valid 8 edges after accept.
//  T2: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1.
//      Carry ripples through all 4 INC passes.
//  T3: a=0x000000FF, b=0, cin=1 -> sum=0x00000100, cout=0.
//  T4: a=0xC8, b=0x64; out_ready low 5 cycles after out_valid.
//      -> sum=0x0000012C held stable, in_ready=0 throughout.
//      Raise out_ready -> IDLE next edge.
//  T5: assert rst 3 edges after accept of a=0x11111111, b=0x22222222.
//      -> out_valid never rises; in_ready=1, sum=0, cout=0, busy=0 immediately.
//      A fresh op then completes correctly.
//  T6 (SKIP_INC_EN): a=0x01010101, b=0x02020202, cin=0 -> sum=0x03030303 after 4 edges.
//      Same op without macro -> 8 edges.

Source files
------------

// File: rtl/csa_8_seq_adder_if.sv
// Operand/result handshake bundle for the byte-serial adder sequencer.
// master: producer/consumer side; slave: adder side.
interface csa_8_seq_adder_if #(
    parameter int NBYTES = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*NBYTES-1:0]   a;
    logic [8*NBYTES-1:0]   b;
    logic                  cin;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   sum;
    logic                  cout;
    logic                  busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/csa_8_seq_adder.sv
// Multi-precision adder: one shared 8-bit adder (no carry-in) processes NBYTES bytes LSB first,
// injecting carry by a second pass per byte. Optional macro SKIP_INC_EN skips that pass when carry is 0.
module csa_8 (
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] S,
    output logic       carry
);
    assign {carry, S} = {1'b0, A} + {1'b0, B};
endmodule

module csa_8_seq_adder #(
    parameter int NBYTES = 4
) (
    input  logic               clk,
    input  logic               rst,
    csa_8_seq_adder_if.slave   bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        INC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [IW-1:0]   idx_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    sum_r;
    logic            cout_r;
    logic            cr_r;
    logic            c1_r;
    logic [7:0]      p_r;
    logic [7:0]      csa_a_s;
    logic [7:0]      csa_b_s;
    logic [7:0]      csa_s_s;
    logic            csa_c_s;
    logic            last_s;
    logic            skip_s;

    assign last_s = (idx_r == IW'(NBYTES - 1));

`ifdef SKIP_INC_EN
    assign skip_s = ~cr_r;
`else
    assign skip_s = 1'b0;
`endif

    csa_8 u_csa (
        .A     (csa_a_s),
        .B     (csa_b_s),
        .S     (csa_s_s),
        .carry (csa_c_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) state_nxt_s = ADD;
                else              state_nxt_s = IDLE;
            end
            ADD: begin
                if (skip_s) begin
                    if (last_s) state_nxt_s = DONE;
                    else        state_nxt_s = ADD;
                end else begin
                    state_nxt_s = INC;
                end
            end
            INC: begin
                if (last_s) state_nxt_s = DONE;
                else        state_nxt_s = ADD;
            end
            DONE: begin
                if (bus.out_ready) state_nxt_s = IDLE;
                else               state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Adder operand select; held at zero outside ADD/INC so the adder stays quiet
    always_comb begin
        csa_a_s = 8'd0;
        csa_b_s = 8'd0;
        case (state_r)
            ADD: begin
                csa_a_s = a_r[{idx_r, 3'b000} +: 8];
                csa_b_s = b_r[{idx_r, 3'b000} +: 8];
            end
            INC: begin
                csa_a_s = p_r;
                csa_b_s = {7'd0, cr_r};
            end
            default: begin
                csa_a_s = 8'd0;
                csa_b_s = 8'd0;
            end
        endcase
    end

    // Datapath registers: operand latch, per-byte partials, result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r  <= '0;
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            cr_r   <= 1'b0;
            c1_r   <= 1'b0;
            p_r    <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r   <= bus.a;
                        b_r   <= bus.b;
                        cr_r  <= bus.cin;
                        idx_r <= '0;
                    end
                end
                ADD: begin
                    if (skip_s) begin
                        sum_r[{idx_r, 3'b000} +: 8] <= csa_s_s;
                        cr_r <= csa_c_s;
                        if (last_s) cout_r <= csa_c_s;
                        else        idx_r  <= idx_r + IW'(1);
                    end else begin
                        p_r  <= csa_s_s;
                        c1_r <= csa_c_s;
                    end
                end
                INC: begin
                    // c1 and the increment carry are mutually exclusive, so OR is the true carry
                    sum_r[{idx_r, 3'b000} +: 8] <= csa_s_s;
                    cr_r <= c1_r | csa_c_s;
                    if (last_s) cout_r <= c1_r | csa_c_s;
                    else        idx_r  <= idx_r + IW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.busy      = (state_r == ADD) || (state_r == INC);
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
endmodule

// File: tb/tb_csa_8_seq_adder.sv
// Directed-vector bench for csa_8_seq_adder (NBYTES=4); latency expectations follow SKIP_INC_EN.
module tb_csa_8_seq_adder;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

`ifdef SKIP_INC_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    csa_8_seq_adder_if #(.NBYTES(4)) bus ();

    csa_8_seq_adder #(.NBYTES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one operation at the current posedge+1 phase and wait for out_valid.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic cv, output int lat);
        bus.a = av; bus.b = bv; bus.cin = cv; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.a = 32'hDEADBEEF; bus.b = 32'hA5A5A5A5; bus.cin = 1'b1;
        check_eq({tag, "_busy"}, 64'(bus.busy), 64'd1);
        check_eq({tag, "_inrdy_busy"}, 64'(bus.in_ready), 64'd0);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_test(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic cv, input logic [31:0] es, input logic ec, input int skip_lat);
        int lat;
        run_op(tag, av, bv, cv, lat);
        check_eq({tag, "_lat"}, 64'(lat), SKIP ? 64'(skip_lat) : 64'd8);
        check_eq({tag, "_sum"}, 64'(bus.sum), 64'(es));
        check_eq({tag, "_cout"}, 64'(bus.cout), 64'(ec));
        check_eq({tag, "_inrdy_done"}, 64'(bus.in_ready), 64'd0);
        if (bus.out_ready) begin
            @(posedge clk); #1;
            check_eq({tag, "_idle"}, 64'(bus.in_ready), 64'd1);
            check_eq({tag, "_ovlow"}, 64'(bus.out_valid), 64'd0);
            check_eq({tag, "_persist"}, 64'(bus.sum), 64'(es));
        end
    endtask

    initial begin
        bit ov_seen;
        int lat;
        n_cmp = 0; n_err = 0;
        clk = 1'b0; rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_inrdy", 64'(bus.in_ready), 64'd1);
        check_eq("rst_ov", 64'(bus.out_valid), 64'd0);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_sum", 64'(bus.sum), 64'd0);
        check_eq("rst_cout", 64'(bus.cout), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_test("T1", 32'h00000019, 32'h00000025, 1'b0, 32'h0000003E, 1'b0, 4);
        do_test("T2", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 7);
        do_test("T3", 32'h000000FF, 32'h00000000, 1'b1, 32'h00000100, 1'b0, 6);
        do_test("T7", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 8);
        do_test("T6", 32'h01010101, 32'h02020202, 1'b0, 32'h03030303, 1'b0, 4);

        // T4: consumer stalls for 5 cycles
        bus.out_ready = 1'b0;
        do_test("T4", 32'h000000C8, 32'h00000064, 1'b0, 32'h0000012C, 1'b0, 5);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq($sformatf("T4_hold_ov%0d", i), 64'(bus.out_valid), 64'd1);
            check_eq($sformatf("T4_hold_rdy%0d", i), 64'(bus.in_ready), 64'd0);
            check_eq($sformatf("T4_hold_sum%0d", i), 64'(bus.sum), 64'h12C);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("T4_release_rdy", 64'(bus.in_ready), 64'd1);
        check_eq("T4_release_ov", 64'(bus.out_valid), 64'd0);

        // T5: reset three edges into an operation
        bus.a = 32'h11111111; bus.b = 32'h22222222; bus.cin = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        ov_seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.out_valid) ov_seen = 1'b1;
        end
        rst = 1'b1;
        #1;
        check_eq("T5_rdy", 64'(bus.in_ready), 64'd1);
        check_eq("T5_sum", 64'(bus.sum), 64'd0);
        check_eq("T5_cout", 64'(bus.cout), 64'd0);
        check_eq("T5_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.out_valid) ov_seen = 1'b1;
        end
        check_eq("T5_no_ov", 64'(ov_seen), 64'd0);
        do_test("T5_fresh", 32'h11111111, 32'h22222222, 1'b0, 32'h33333333, 1'b0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
